// File: rtl/exp_share_sched.sv
// Round-robin sharing of one fixed-latency exp pipeline among NUM_REQ requesters.
// Results come back tagged with their requester and queue in a first-word-fall-through FIFO.
module exp_share_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 18,
    parameter int EXP_LAT    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      exp_in_valid,
    output logic [DATA_W-1:0]         exp_in_data,
    input  logic                      exp_out_valid,
    input  logic [DATA_W-1:0]         exp_out_data,
    output logic                      rsp_valid,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      rsp_ready,
    output logic                      busy,
    output logic                      err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [TAG_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        outst_q, outst_d;
    logic                    exp_in_valid_q, exp_in_valid_d;
    logic [DATA_W-1:0]       exp_in_data_q, exp_in_data_d;
    logic [TAG_W-1:0]        exp_in_tag_q, exp_in_tag_d;
    logic [EXP_LAT-1:0]      tp_valid_q, tp_valid_d;
    logic [TAG_W-1:0]        tp_tag_q [EXP_LAT];
    logic [TAG_W-1:0]        tp_tag_d [EXP_LAT];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic                    err_q, err_d;
    logic [TAG_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic [DATA_W-1:0]       req_word [NUM_REQ];
    logic [TAG_W-1:0]        cand;
    logic [TAG_W-1:0]        grant_idx;
    logic                    grant_found;
    logic                    credit_ok;
    logic                    issue;
    logic                    pop;
    logic                    wr_en;
    logic [TAG_W-1:0]        wr_tag;
    logic [TAG_W+DATA_W-1:0] head;

    assign credit_ok = outst_q < CNT_W'(FIFO_DEPTH);

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_word[gi]  = req_data[gi*DATA_W +: DATA_W];
            // Gated by rst_n so the grant is silent while reset is held.
            assign req_ready[gi] = rst_n & credit_ok & grant_found & (grant_idx == TAG_W'(gi));
        end
    endgenerate

    assign issue     = |(req_valid & req_ready);
    assign rsp_valid = (fifo_cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    // A spurious result (no tag in flight) is still stored, under tag 0.
    assign wr_tag    = tp_valid_q[EXP_LAT-1] ? tp_tag_q[EXP_LAT-1] : '0;
    assign wr_en     = exp_out_valid & ((fifo_cnt_q != CNT_W'(FIFO_DEPTH)) | pop);
    assign head      = fifo_mem[rd_ptr_q];

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        outst_d        = outst_q;
        exp_in_valid_d = issue;
        exp_in_data_d  = exp_in_data_q;
        exp_in_tag_d   = exp_in_tag_q;
        err_d          = err_q | (exp_out_valid != tp_valid_q[EXP_LAT-1]);
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        fifo_cnt_d     = fifo_cnt_q;

        if (issue) begin
            rr_ptr_d      = (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            exp_in_data_d = req_word[grant_idx];
            exp_in_tag_d  = grant_idx;
        end

        if (issue && !(pop && outst_q != '0))
            outst_d = outst_q + 1'b1;
        else if (!issue && pop && outst_q != '0)
            outst_d = outst_q - 1'b1;

        // Tag pipe is fed from the issue register so its last stage meets exp_out_valid.
        tp_valid_d[0] = exp_in_valid_q;
        tp_tag_d[0]   = exp_in_tag_q;
        for (int k = 1; k < EXP_LAT; k++) begin
            tp_valid_d[k] = tp_valid_q[k-1];
            tp_tag_d[k]   = tp_tag_q[k-1];
        end

        if (wr_en)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en && !pop)
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!wr_en && pop)
            fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            outst_q        <= '0;
            exp_in_valid_q <= 1'b0;
            exp_in_data_q  <= '0;
            exp_in_tag_q   <= '0;
            tp_valid_q     <= '0;
            for (int k = 0; k < EXP_LAT; k++)
                tp_tag_q[k] <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            outst_q        <= outst_d;
            exp_in_valid_q <= exp_in_valid_d;
            exp_in_data_q  <= exp_in_data_d;
            exp_in_tag_q   <= exp_in_tag_d;
            tp_valid_q     <= tp_valid_d;
            tp_tag_q       <= tp_tag_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            err_q          <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem[wr_ptr_q] <= {wr_tag, exp_out_data};
    end

    assign exp_in_valid = exp_in_valid_q;
    assign exp_in_data  = exp_in_data_q;
    assign rsp_tag      = rsp_valid ? head[TAG_W+DATA_W-1:DATA_W] : '0;
    assign rsp_data     = rsp_valid ? head[DATA_W-1:0] : '0;
    assign busy         = (outst_q != '0) | exp_in_valid_q;
    assign err          = err_q;
endmodule

// File: tb/tb_exp_share_sched.sv
// Bench for exp_share_sched: behavioural exp pipeline plus an issue-order scoreboard
// that predicts grants, credits, response timing and contents.
module tb_exp_share_sched;
    localparam int NR  = 4;
    localparam int DW  = 18;
    localparam int LAT = 3;
    localparam int FD  = 8;
    localparam int TW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              exp_in_valid;
    logic [DW-1:0]     exp_in_data;
    logic              exp_out_valid = 1'b0;
    logic [DW-1:0]     exp_out_data = '0;
    logic              rsp_valid;
    logic [TW-1:0]     rsp_tag;
    logic [DW-1:0]     rsp_data;
    logic              rsp_ready = 1'b0;
    logic              busy;
    logic              err;

    exp_share_sched #(.NUM_REQ(NR), .DATA_W(DW), .EXP_LAT(LAT), .FIFO_DEPTH(FD), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .exp_in_valid(exp_in_valid), .exp_in_data(exp_in_data),
        .exp_out_valid(exp_out_valid), .exp_out_data(exp_out_data),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [DW-1:0] data;
        int          rdy;
    } item_t;

    item_t         q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rr_m = 0;
    bit            prev_iss = 0;
    logic [DW-1:0] prev_data = '0;
    bit            chk_en = 1;
    int            late = 0;
    bit            fix_en = 0;
    logic [DW-1:0] fix_val = '0;
    logic [DW:0]   dl [LAT+2];

    // Q8.10 exponent, saturated at the largest positive code.
    function automatic logic [DW-1:0] exp_fn(input logic [DW-1:0] x);
        real r;
        r = $exp($itor($signed(x)) / 1024.0) * 1024.0;
        if (r >= 131071.0) return 18'h1FFFF;
        return DW'($rtoi(r));
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", nm, obs, expv, cyc);
        end
    endtask

    // One clock cycle: entered 1 time unit after a rising edge.
    task automatic tick(input logic [NR-1:0] v, input bit rdy);
        logic [DW-1:0] words [NR];
        int            g;
        logic [NR-1:0] exp_ready;
        bit            evv;
        for (int k = LAT + 1; k > 0; k--) dl[k] = dl[k-1];
        dl[0]         = {exp_in_valid, exp_in_data};
        exp_out_valid = dl[LAT+late][DW];
        exp_out_data  = exp_fn(dl[LAT+late][DW-1:0]);
        for (int i = 0; i < NR; i++) begin
            words[i] = fix_en ? fix_val : DW'($urandom);
            req_data[i*DW +: DW] = words[i];
        end
        req_valid = v;
        rsp_ready = rdy;
        #1;
        g = -1;
        if (q.size() < FD)
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (rr_m + k) % NR;
                if (g < 0 && v[i]) g = i;
            end
        exp_ready = (g >= 0) ? NR'(1 << g) : '0;
        evv = (q.size() > 0) && (q[0].rdy <= cyc);
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("exp_in_valid", 32'(exp_in_valid), 32'(prev_iss));
            if (prev_iss) chk("exp_in_data", 32'(exp_in_data), 32'(prev_data));
            chk("rsp_valid", 32'(rsp_valid), 32'(evv));
            if (evv) begin
                chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
                chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
            end
            chk("busy", 32'(busy), 32'((q.size() != 0) || prev_iss));
            chk("err", 32'(err), 32'd0);
        end
        if (evv && rdy) begin
            $display("cyc %0d rsp tag=%0d data=%05h", cyc, q[0].tag, q[0].data);
            void'(q.pop_front());
        end
        if (g >= 0) begin
            q.push_back('{tag: g, data: exp_fn(words[g]), rdy: cyc + LAT + 2});
            rr_m      = (g + 1) % NR;
            prev_data = words[g];
        end
        prev_iss = (g >= 0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_exp_in_valid", 32'(exp_in_valid), 32'd0);
        chk("rst_exp_in_data", 32'(exp_in_data), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        q.delete();
        rr_m = 0;
        prev_iss = 0;
        exp_out_valid = 1'b0;
        for (int k = 0; k < LAT + 2; k++) dl[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < LAT + 2; k++) dl[k] = '0;
        req_valid = 4'b1111;
        #3;
        do_reset();

        // Single request of 1.0 -> e (0x00ADF)
        fix_en = 1; fix_val = 18'h00400;
        tick(4'b0001, 1'b1);
        fix_en = 0;
        repeat (7) tick(4'b0000, 1'b1);

        // All requesters busy, consumer always ready
        repeat (20) tick(4'b1111, 1'b1);
        repeat (6) tick(4'b0000, 1'b1);

        // Back-pressure fills the credits, then release
        repeat (14) tick(4'b1010, 1'b0);
        repeat (20) tick(4'b1010, 1'b1);
        repeat (8) tick(4'b0000, 1'b1);

        // Random traffic
        repeat (400) tick(NR'($urandom), ($urandom_range(0, 3) != 0));
        repeat (12) tick(4'b0000, 1'b1);

        // Reset with results both in flight and buffered
        repeat (5) tick(4'b1111, 1'b0);
        repeat (2) tick(4'b1111, 1'b0);
        do_reset();
        repeat (3) tick(4'b0110, 1'b1);
        repeat (10) tick(4'b0000, 1'b1);

        // Pipeline returns one cycle late
        late = 1; chk_en = 0;
        tick(4'b0001, 1'b1);
        repeat (8) tick(4'b0000, 1'b1);
        chk("err_set", 32'(err), 32'd1);
        repeat (5) tick(4'b0000, 1'b1);
        chk("err_sticky", 32'(err), 32'd1);
        late = 0;
        do_reset();
        chk_en = 1;
        repeat (60) tick(NR'($urandom), ($urandom_range(0, 2) != 0));
        repeat (12) tick(4'b0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
